// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO between the UART receiver and the host port.
// Stores {error flags, data} per character and provides peek, status flags and RTS.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Wr_En,
  input  logic [DATA_BITS-1:0] Wr_Data,
  input  logic [2:0]           Wr_Err,
  input  logic                 Pop_Data,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  output logic [2:0]           Rx_Err_Out,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS
);

  localparam int unsigned ENTRIES = 2 ** FIFO_WIDTH;
  localparam int unsigned CW      = FIFO_WIDTH + 1;
  localparam int unsigned WW      = DATA_BITS + 3;
  localparam logic [CW-1:0] MAX_CNT  = CW'(ENTRIES);
  localparam logic [CW-1:0] FULL_LVL = CW'(ENTRIES / 2 + 1);

  logic [WW-1:0]         mem [ENTRIES];
  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;

  logic                  pop_ok;
  logic                  wr_ok;
  logic                  drop;
  logic [FIFO_WIDTH-1:0] rd_next;
  logic [CW-1:0]         remain;
  logic [CW-1:0]         count_next;
  logic [2:0]            head_next;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  always_comb begin
    pop_ok     = Pop_Data && (count != '0);
    wr_ok      = Wr_En && ((count != MAX_CNT) || pop_ok);
    drop       = Wr_En && !wr_ok;
    rd_next    = rd_ptr + FIFO_WIDTH'(pop_ok);
    remain     = count - CW'(pop_ok);
    count_next = remain + CW'(wr_ok);
    head_next  = '0;
    if (remain != '0) begin
      head_next = mem[rd_next][WW-1:DATA_BITS];
    end else if (wr_ok) begin
      head_next = Wr_Err;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {Wr_Err, Wr_Data};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      Data_Out      <= '0;
      Rx_Err_Out    <= '0;
      Data_Rdy      <= 1'b0;
      Rx_Error      <= '0;
      FIFO_Empty    <= 1'b1;
      FIFO_Full     <= 1'b0;
      FIFO_Overflow <= 1'b0;
      RTS           <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + FIFO_WIDTH'(1);
      end
      rd_ptr   <= rd_next;
      count    <= count_next;
      Data_Rdy <= pop_ok;
      if (pop_ok) begin
        Data_Out   <= mem[rd_ptr][DATA_BITS-1:0];
        Rx_Err_Out <= mem[rd_ptr][WW-1:DATA_BITS];
      end
      Rx_Error   <= head_next;
      FIFO_Empty <= (count_next == '0);
      FIFO_Full  <= (count_next >= FULL_LVL);
      RTS        <= (count_next < FULL_LVL);
      // Sticky drop indicator; the first accepted pop clears it.
      if (pop_ok) begin
        FIFO_Overflow <= 1'b0;
      end else if (drop) begin
        FIFO_Overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

  localparam int unsigned DB = 8;
  localparam int unsigned FW = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FULL_AT = 5;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Wr_En;
  logic [DB-1:0] Wr_Data;
  logic [2:0]    Wr_Err;
  logic          Pop_Data;
  logic [DB-1:0] Data_Out;
  logic          Data_Rdy;
  logic [2:0]    Rx_Error;
  logic [2:0]    Rx_Err_Out;
  logic          FIFO_Empty;
  logic          FIFO_Full;
  logic          FIFO_Overflow;
  logic          RTS;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.DATA_BITS(DB), .FIFO_WIDTH(FW)) dut (
    .Clk(Clk), .Rst(Rst), .Wr_En(Wr_En), .Wr_Data(Wr_Data), .Wr_Err(Wr_Err),
    .Pop_Data(Pop_Data), .Data_Out(Data_Out), .Data_Rdy(Data_Rdy),
    .Rx_Error(Rx_Error), .Rx_Err_Out(Rx_Err_Out), .FIFO_Empty(FIFO_Empty),
    .FIFO_Full(FIFO_Full), .FIFO_Overflow(FIFO_Overflow), .RTS(RTS)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of {flags, data}.
  logic [DB+2:0] q[$];
  logic          m_valid = 1'b0;
  logic [DB-1:0] m_dout;
  logic [2:0]    m_eout;
  logic          m_rdy;
  logic          m_ovf;

  always @(posedge Clk) begin
    if (Rst) begin
      q.delete();
      m_dout  = '0;
      m_eout  = '0;
      m_rdy   = 1'b0;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_rdy = Pop_Data && (q.size() > 0);
      if (m_rdy) begin
        m_dout = q[0][DB-1:0];
        m_eout = q[0][DB+2:DB];
        void'(q.pop_front());
        m_ovf = 1'b0;
      end
      if (Wr_En) begin
        if (q.size() < DEPTH) q.push_back({Wr_Err, Wr_Data});
        else m_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("data_out", 32'(Data_Out), 32'(m_dout));
      chk("err_out", 32'(Rx_Err_Out), 32'(m_eout));
      chk("data_rdy", 32'(Data_Rdy), 32'(m_rdy));
      chk("rx_error", 32'(Rx_Error), (q.size() > 0) ? 32'(q[0][DB+2:DB]) : 32'd0);
      chk("empty", 32'(FIFO_Empty), 32'(q.size() == 0));
      chk("full", 32'(FIFO_Full), 32'(q.size() >= FULL_AT));
      chk("rts", 32'(RTS), 32'(q.size() < FULL_AT));
      chk("overflow", 32'(FIFO_Overflow), 32'(m_ovf));
    end
  end

  task automatic cyc(input logic w, input logic [DB-1:0] d, input logic [2:0] e, input logic p);
    Wr_En = w; Wr_Data = d; Wr_Err = e; Pop_Data = p;
    @(posedge Clk); #1;
    Wr_En = 1'b0; Pop_Data = 1'b0; Wr_Data = '0; Wr_Err = '0;
  endtask

  initial begin
    Rst = 1'b1; Wr_En = 1'b0; Wr_Data = '0; Wr_Err = '0; Pop_Data = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    chk("rst_empty", 32'(FIFO_Empty), 32'd1);
    chk("rst_full", 32'(FIFO_Full), 32'd0);
    chk("rst_ovf", 32'(FIFO_Overflow), 32'd0);
    chk("rst_rts", 32'(RTS), 32'd1);
    chk("rst_dout", 32'(Data_Out), 32'd0);
    chk("rst_rxerr", 32'(Rx_Error), 32'd0);

    // Single entry, popped two cycles after the write
    cyc(1'b1, 8'hA5, 3'b000, 1'b0);
    chk("single_notempty", 32'(FIFO_Empty), 32'd0);
    cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1);
    chk("single_dout", 32'(Data_Out), 32'hA5);
    chk("single_rdy", 32'(Data_Rdy), 32'd1);
    chk("single_empty", 32'(FIFO_Empty), 32'd1);
    cyc(1'b0, '0, '0, 1'b0);
    chk("single_rdy_drop", 32'(Data_Rdy), 32'd0);

    // Fill 0..7; Full rises on the 5th write
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, DB'(i), 3'(i), 1'b0);
      if (i == 3) chk("fill4_full", 32'(FIFO_Full), 32'd0);
      if (i == 4) begin
        chk("fill5_full", 32'(FIFO_Full), 32'd1);
        chk("fill5_rts", 32'(RTS), 32'd0);
      end
    end
    // Overflow: 0x99 dropped
    cyc(1'b1, 8'h99, 3'b111, 1'b0);
    chk("ovf_set", 32'(FIFO_Overflow), 32'd1);
    chk("ovf_full", 32'(FIFO_Full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0, 1'b1);
      chk("drain_dout", 32'(Data_Out), 32'(i));
      if (i == 0) chk("ovf_clear", 32'(FIFO_Overflow), 32'd0);
      if (i == 2) chk("drain5_full", 32'(FIFO_Full), 32'd1);
      if (i == 3) chk("drain4_full", 32'(FIFO_Full), 32'd0);
    end
    chk("drain_empty", 32'(FIFO_Empty), 32'd1);
    cyc(1'b0, '0, '0, 1'b1);
    chk("pop_empty_rdy", 32'(Data_Rdy), 32'd0);
    chk("pop_empty_hold", 32'(Data_Out), 32'd7);

    // Error peek
    cyc(1'b1, 8'hAA, 3'b010, 1'b0);
    chk("peek_rxerr", 32'(Rx_Error), 32'b010);
    cyc(1'b0, '0, '0, 1'b1);
    chk("peek_errout", 32'(Rx_Err_Out), 32'b010);
    chk("peek_dout", 32'(Data_Out), 32'hAA);
    chk("peek_cleared", 32'(Rx_Error), 32'd0);

    // Write + pop while empty: write wins, pop ignored
    cyc(1'b1, 8'h11, 3'b001, 1'b1);
    chk("sim_empty_rdy", 32'(Data_Rdy), 32'd0);
    chk("sim_empty_empty", 32'(FIFO_Empty), 32'd0);
    chk("sim_empty_rxerr", 32'(Rx_Error), 32'b001);
    cyc(1'b0, '0, '0, 1'b1);
    chk("sim_empty_pop", 32'(Data_Out), 32'h11);

    // Write + pop while full: both accepted, no overflow
    for (int i = 0; i < 8; i++) cyc(1'b1, DB'(8'h20 + i), 3'b100, 1'b0);
    cyc(1'b1, 8'h55, 3'b011, 1'b1);
    chk("sim_full_dout", 32'(Data_Out), 32'h20);
    chk("sim_full_ovf", 32'(FIFO_Overflow), 32'd0);
    chk("sim_full_full", 32'(FIFO_Full), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b1);
    chk("sim_full_last", 32'(Data_Out), 32'h55);
    chk("sim_full_lasterr", 32'(Rx_Err_Out), 32'b011);

    // Reset while holding 3 entries
    for (int i = 0; i < 3; i++) cyc(1'b1, DB'(8'h40 + i), 3'b101, 1'b0);
    Rst = 1'b1;
    cyc(1'b0, '0, '0, 1'b0);
    Rst = 1'b0;
    chk("midrst_empty", 32'(FIFO_Empty), 32'd1);
    chk("midrst_rxerr", 32'(Rx_Error), 32'd0);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 4000; n++) begin
      int unsigned wp;
      int unsigned pp;
      wp = ((n / 150) % 2 == 0) ? 85 : 30;
      pp = ((n / 150) % 2 == 0) ? 25 : 75;
      Rst      = ($urandom % 400) == 0;
      Wr_En    = ($urandom % 100) < wp;
      Wr_Data  = DB'($urandom);
      Wr_Err   = 3'($urandom);
      Pop_Data = ($urandom % 100) < pp;
      @(posedge Clk); #1;
    end
    Rst = 1'b0; Wr_En = 1'b0; Pop_Data = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver and the host-facing UART port.
- Captures each received character with its 3 error flags, then presents them in order on Data_Out / Rx_Error when Pop_Data is strobed.
- Generates FIFO_Empty, FIFO_Full (half full plus one), FIFO_Overflow and RTS flow control back to the remote transmitter.

Parameters:
DATA_BITS, 8, width of one received character
FIFO_WIDTH, 8, address bits; depth FIFO_ENTRIES = 2**FIFO_WIDTH (legal 2..8)

Ports:
Clk  input  1  single clock for all logic
Rst  input  1  synchronous, active-high reset
Wr_En  input  1  receiver strobe, one cycle per completed character
Wr_Data  input  DATA_BITS  received character, valid with Wr_En
Wr_Err  input  3  {frame, parity, break} flags for the character, valid with Wr_En
Pop_Data  input  1  host strobe: move the head entry onto the outputs
Data_Out  output  DATA_BITS  last popped character
Data_Rdy  output  1  one-cycle pulse when Data_Out / Rx_Err_Out is newly loaded
Rx_Error  output  3  error flags of the current head entry (peek, no pop needed)
Rx_Err_Out  output  3  error flags of the last popped character
FIFO_Empty  output  1  count == 0
FIFO_Full  output  1  count >= FIFO_ENTRIES/2 + 1
FIFO_Overflow  output  1  sticky: a write was dropped
RTS  output  1  ready to receive = !FIFO_Full

Behaviour:
- **Clock and reset:** one clock (Clk). Reset is synchronous and active-high (Rst).
- **Reset values:** on a Rst-high posedge:
  - pointers = 0, count = 0
  - Data_Out = 0, Rx_Err_Out = 0, Data_Rdy = 0, Rx_Error = 0
  - FIFO_Empty = 1, FIFO_Full = 0, FIFO_Overflow = 0, RTS = 1
  - Reset mid-operation discards all stored entries. Memory contents need not be cleared.
- **Storage:** FIFO_ENTRIES words of DATA_BITS+3 bits.
  - Write pointer and read pointer are FIFO_WIDTH bits wide and wrap modulo FIFO_ENTRIES.
  - count is FIFO_WIDTH+1 bits wide, range 0..FIFO_ENTRIES.
- **Write:** Wr_En with count < FIFO_ENTRIES stores {Wr_Err, Wr_Data} at the write pointer, then increments the write pointer and count.
- **Write when full:** Wr_En with count == FIFO_ENTRIES and no accepted pop in the same cycle drops the data and sets FIFO_Overflow. Pointers and count are unchanged.
- **Pop:** Pop_Data with count > 0 does the following at the next posedge:
  - Data_Out ← head data, Rx_Err_Out ← head flags.
  - Read pointer increments and count decrements.
  - Data_Rdy = 1 for exactly that cycle.
  - Pop latency is 1 cycle.
- **Pop on empty:** ignored. Data_Out holds, Data_Rdy = 0.
- **Pop_Data held high:** each cycle counts as a new pop request. Hosts pulse it for one cycle.
- **Simultaneous write and pop:**
  - Empty: the write is accepted and the pop is ignored. Count becomes 1.
  - Full: both are accepted. Count stays FIFO_ENTRIES and no overflow occurs.
  - Otherwise: both are accepted and count is unchanged.
- **Rx_Error (peek):**
  - Registered copy of the head entry's flags. It equals 0 when the FIFO is empty.
  - It updates on the cycle after a write into an empty FIFO, and on the cycle after a pop.
  - This lets the host check the error status of the oldest entry before deciding to pop it.
- **Status flags:** FIFO_Empty, FIFO_Full and RTS are registered from the next-state count, so they are valid on the same edge that count changes.
- **FIFO_Full threshold:** asserts when count reaches FIFO_ENTRIES/2+1 and deasserts when count falls below it.
- **FIFO_Overflow clear:** cleared by the first accepted pop after it was set, or by Rst. A drop that coincides with a pop cannot happen, because an accepted pop frees a slot in the same cycle.
- **Control structure:** no separate FSM. Control is the count/pointer datapath plus the sticky overflow flag.

Test Plan (bench uses FIFO_WIDTH=3, 8 entries, Full at 5):
- **Reset:** Rst for 2 cycles → Empty=1, Full=0, Overflow=0, RTS=1, Data_Out=0, Rx_Error=0.
- **Single entry:** write 0xA5 with Wr_Err=3'b000, then pop 2 cycles later → Data_Out=0xA5 and Data_Rdy pulses 1 cycle after Pop_Data. Empty returns to 1.
- **Fill and drain:**
  - Write 0..7 → Full rises on the 5th write, RTS falls.
  - Pop all 8 → values 0..7 in order. Full falls when count reaches 4, and Empty=1 after the 8th pop.
- **Overflow:**
  - With 8 entries stored, write 0x99 → Overflow=1 and count stays 8.
  - Pop → Data_Out=0x00 (oldest entry) and Overflow clears. 0x99 is never read.
- **Error peek:**
  - Write 0xAA with Wr_Err=3'b010 into an empty FIFO → Rx_Error=3'b010 one cycle later with no pop.
  - Pop → Rx_Err_Out=3'b010, then Rx_Error=0.
- **Simultaneous events:**
  - Write and pop while empty → count 1, Data_Rdy=0.
  - Write and pop while full → count 8, Overflow=0.
  - Rst asserted while holding 3 entries → Empty=1 next cycle.
